sumador_serial: RTL and testbench

SUMADOR_SERIAL -- requirements
Module: sumador_serial

---
 rtl/sumador_serial.sv | 70 +++++++
 tb/tb_sumador_serial.sv | 105 ++++++++++
 2 files changed

// File: rtl/sumador_serial.sv
// sumador_serial: digit-serial adder that adds D bits per clock over N/D cycles with a valid/ready handshake on both sides.
// Define SUMADOR_SAT_EN to saturate sum_o to all ones when the final carry is set.
module sumador_serial #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         valid_o,
  input  logic         ready_i
);
  localparam int S  = N / D;
  localparam int KW = S > 1 ? $clog2(S) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] a_q, b_q, sum_q;
  logic [KW-1:0] k_q;
  logic carry_q, cout_q, last;
  logic [D:0] slice;
  assign last = k_q == KW'(S - 1);
  assign slice = {1'b0, a_q[int'(k_q)*D +: D]} + {1'b0, b_q[int'(k_q)*D +: D]} + (D+1)'(carry_q);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = valid_i ? BUSY : IDLE;
      BUSY:    state_nx = last ? DONE : BUSY;
      DONE:    state_nx = ready_i ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (state == IDLE && valid_i) begin
      a_q     <= a_i;
      b_q     <= b_i;
      carry_q <= cin_i;
      k_q     <= '0;
    end else if (state == BUSY) begin
      sum_q[int'(k_q)*D +: D] <= slice[D-1:0];
      carry_q <= slice[D];
      k_q     <= last ? '0 : k_q + 1'b1;
      if (last) begin
        cout_q <= slice[D];
`ifdef SUMADOR_SAT_EN
        if (slice[D]) sum_q <= '1;
`endif
      end
    end
  end
  assign ready_o = state == IDLE;
  assign valid_o = state == DONE;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
endmodule

// File: tb/tb_sumador_serial.sv
// tb_sumador_serial: random and directed operations checked against an arithmetic reference model.
module tb_sumador_serial;
  localparam int N = 8, D = 2, S = N / D;
  logic clk_i = 0, rst_n_i = 0, cin_i = 0, valid_i = 0, ready_i = 0;
  logic ready_o, cout_o, valid_o;
  logic [N-1:0] a_i = '0, b_i = '0, sum_o;
  int errors = 0, checks = 0;
  always #5 clk_i = ~clk_i;
  sumador_serial #(.N(N), .D(D)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .a_i(a_i), .b_i(b_i), .cin_i(cin_i),
    .valid_i(valid_i), .ready_o(ready_o), .sum_o(sum_o), .cout_o(cout_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    logic [N:0] f;
    f = {1'b0, a} + {1'b0, b} + (N+1)'(c);
`ifdef SUMADOR_SAT_EN
    if (f[N]) f = '1;
`endif
    return f;
  endfunction
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input int hold);
    logic [N:0] e;
    int edges;
    e = ref_add(a, b, c);
    check("ready_idle", 32'(ready_o), 1);
    a_i = a; b_i = b; cin_i = c; valid_i = 1;
    @(posedge clk_i); #1;
    valid_i = 0; a_i = N'($urandom); b_i = N'($urandom); cin_i = ~c;
    edges = 0;
    do begin
      @(posedge clk_i); #1;
      edges++;
    end while (!valid_o && edges < 20);
    check("latency", 32'(edges), S);
    check("result", 32'({cout_o, sum_o}), 32'(e));
    check("ready_done", 32'(ready_o), 0);
    for (int i = 0; i < hold; i++) begin
      valid_i = 1; a_i = N'($urandom); b_i = N'($urandom);
      @(posedge clk_i); #1;
      check("hold_valid", 32'(valid_o), 1);
      check("hold_ready", 32'(ready_o), 0);
      check("hold_result", 32'({cout_o, sum_o}), 32'(e));
    end
    valid_i = 0; ready_i = 1;
    @(posedge clk_i); #1;
    ready_i = 0;
    check("handoff_valid", 32'(valid_o), 0);
    check("handoff_ready", 32'(ready_o), 1);
  endtask
  initial begin
    int acc[$];
    logic [N:0] pe;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(ready_o), 1);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_result", 32'({cout_o, sum_o}), 0);
    @(negedge clk_i);
    rst_n_i = 1;
    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 0);
    run_op(8'h05, 8'h04, 1'b0, 5);
    run_op(8'hFF, 8'hFF, 1'b0, 2);
    run_op(8'h80, 8'h80, 1'b1, 0);
    for (int i = 0; i < 20; i++)
      run_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    run_op(8'h12, 8'h34, 1'b0, 0);
    a_i = 8'h9A; b_i = 8'h77; valid_i = 1;
    @(posedge clk_i); #1;
    valid_i = 0;
    @(posedge clk_i); #1;
    rst_n_i = 0;
    #1;
    check("abort_valid", 32'(valid_o), 0);
    check("abort_result", 32'({cout_o, sum_o}), 0);
    check("abort_ready", 32'(ready_o), 1);
    repeat (S + 1) @(posedge clk_i);
    #1;
    check("abort_no_result", 32'(valid_o), 0);
    @(negedge clk_i);
    rst_n_i = 1;
    run_op(8'h3C, 8'h5A, 1'b1, 0);
    pe = ref_add(8'h77, 8'h11, 1'b1);
    a_i = 8'h77; b_i = 8'h11; cin_i = 1; valid_i = 1; ready_i = 1;
    for (int i = 0; i <= 3 * (S + 2); i++) begin
      if (ready_o) acc.push_back(i);
      if (valid_o) check("pipe_result", 32'({cout_o, sum_o}), 32'(pe));
      @(posedge clk_i); #1;
    end
    valid_i = 0; ready_i = 0;
    check("pipe_accepts", 32'(acc.size()), 4);
    for (int i = 1; i < acc.size(); i++)
      check("pipe_interval", 32'(acc[i] - acc[i-1]), S + 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
